// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - load/step/write sequencer for the iterative multiplier and divider
module muldiv_sequencer #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             div_zero,
    output logic             busy,
    output logic             load_en,
    output logic             step_en,
    output logic             op_div,
    output logic             hilo_write,
    output logic             done,
    output logic             div_zero_exc,
    output logic [CNT_W-1:0] iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_WRITE = 3'd3,
        S_EXC   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_q, state_d;
    logic             op_div_q, op_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_cnt;

    assign last_cnt = op_div_q ? DIV_LAST : MULT_LAST;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            op_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_div_q <= op_div_d;
            cnt_q    <= cnt_d;
        end
    end

    // Multiply takes priority; a divide by zero skips the unit entirely so HI/LO stay intact.
    always_comb begin
        state_d  = state_q;
        op_div_d = op_div_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_mult) begin
                    state_d  = S_LOAD;
                    op_div_d = 1'b0;
                end else if (start_div) begin
                    if (div_zero) begin
                        state_d = S_EXC;
                    end else begin
                        state_d  = S_LOAD;
                        op_div_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == last_cnt) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_IDLE;
            S_EXC:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy         = (state_q != S_IDLE);
    assign load_en      = (state_q == S_LOAD);
    assign step_en      = (state_q == S_RUN);
    assign hilo_write   = (state_q == S_WRITE);
    assign done         = (state_q == S_WRITE);
    assign div_zero_exc = (state_q == S_EXC);
    assign op_div       = op_div_q;
    assign iter_cnt     = cnt_q;

endmodule
